// File: rtl/osd_pkg.sv
// Shared definitions for the on-screen-display text console.
// Holds default geometry, control codes, FSM encoding and byte classification.
package osd_pkg;

    localparam int C_CHARS_X = 64;
    localparam int C_CHARS_Y = 24;
    localparam int ADDR_W    = 11;
    localparam int N_CELLS   = C_CHARS_X * C_CHARS_Y;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_PUT         = 3'd1;
    localparam logic [2:0] S_CLEAR       = 3'd2;
    localparam logic [2:0] S_SCROLL_RD   = 3'd3;
    localparam logic [2:0] S_SCROLL_WR   = 3'd4;
    localparam logic [2:0] S_SCROLL_FILL = 3'd5;

    typedef enum logic [2:0] {
        K_PRINT,
        K_CR,
        K_LF,
        K_BS,
        K_FF,
        K_NOP
    } ch_kind_e;

    function automatic int osd_cells(input int cx, input int cy);
        return cx * cy;
    endfunction

    function automatic ch_kind_e osd_kind(input logic [7:0] b);
        ch_kind_e k;
        unique case (1'b1)
            (b == CH_CR):                    k = K_CR;
            (b == CH_LF):                    k = K_LF;
            (b == CH_BS):                    k = K_BS;
            (b == CH_FF):                    k = K_FF;
            (b >= CH_SPACE && b != CH_DEL):  k = K_PRINT;
            default:                         k = K_NOP;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/osd_ram_arb.sv
// Single-port tile RAM mux: the host write path always wins,
// the console FSM only gets the port on cycles the host leaves free.
module osd_ram_arb
    import osd_pkg::*;
#(
    parameter int DW = 9
)(
    input  logic              en,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DW-1:0]     host_data,
    input  logic              fsm_we,
    input  logic              fsm_re,
    input  logic [ADDR_W-1:0] fsm_addr,
    input  logic [DW-1:0]     fsm_wdata,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic              fsm_gnt
);

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        fsm_gnt   = 1'b0;
        if (en) begin
            if (host_wr) begin
                ram_we    = 1'b1;
                ram_addr  = host_addr;
                ram_wdata = host_data;
            end else begin
                ram_we    = fsm_we;
                ram_re    = fsm_re & ~fsm_we;
                ram_addr  = fsm_addr;
                ram_wdata = fsm_wdata;
                fsm_gnt   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_console.sv
// Character-stream text console writing into a shared tile RAM.
// Handles printable bytes, CR/LF/BS/FF, screen clear and hardware scroll.
module osd_console
    import osd_pkg::*;
#(
    parameter int c_chars_x = C_CHARS_X,
    parameter int c_chars_y = C_CHARS_Y,
    parameter int c_inverse = 1
)(
    input  logic                 clk_pixel,
    input  logic                 rst_n,
    input  logic                 i_ch_valid,
    input  logic [7:0]           i_ch_data,
    output logic                 o_ch_ready,
    input  logic                 i_inv,
    input  logic                 i_host_wr,
    input  logic [ADDR_W-1:0]    i_host_addr,
    input  logic [7+c_inverse:0] i_host_data,
    output logic                 o_ram_we,
    output logic                 o_ram_re,
    output logic [ADDR_W-1:0]    o_ram_addr,
    output logic [7+c_inverse:0] o_ram_wdata,
    input  logic [7+c_inverse:0] i_ram_rdata,
    output logic [5:0]           o_cursor_x,
    output logic [4:0]           o_cursor_y,
    output logic                 o_busy
);

    localparam int DW = 8 + c_inverse;
    localparam int N  = osd_cells(c_chars_x, c_chars_y);

    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] A_ROW1  = ADDR_W'(c_chars_x);
    localparam logic [ADDR_W-1:0] A_FILL  = ADDR_W'(N - c_chars_x);
    localparam logic [ADDR_W-1:0] A_COLS  = ADDR_W'(c_chars_x);
    localparam logic [5:0]        X_LAST  = 6'(c_chars_x - 1);
    localparam logic [4:0]        Y_LAST  = 5'(c_chars_y - 1);
    localparam logic [DW-1:0]     W_SPACE = DW'(CH_SPACE);

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [5:0]        cur_x;
    logic [4:0]        cur_y;
    logic [7:0]        put_byte;
    logic              put_inv;
    logic              rd_pend;
    logic [DW-1:0]     hold;

    logic              fsm_we;
    logic              fsm_re;
    logic              fsm_gnt;
    logic [ADDR_W-1:0] fsm_addr;
    logic [DW-1:0]     fsm_wdata;
    logic [DW-1:0]     put_word;
    logic [ADDR_W-1:0] cur_addr;
    logic              accept;
    ch_kind_e          kind;

    assign o_ch_ready = rst_n & (state == S_IDLE) & ~i_host_wr;
    assign accept     = i_ch_valid & o_ch_ready;
    assign kind       = osd_kind(i_ch_data);
    assign o_busy     = (state != S_IDLE);
    assign o_cursor_x = cur_x;
    assign o_cursor_y = cur_y;
    assign cur_addr   = ADDR_W'(cur_y) * A_COLS + ADDR_W'(cur_x);

    always_comb begin
        put_word = DW'(put_byte);
        if (c_inverse != 0) put_word[DW-1] = put_inv;
    end

    // Read data arrives a cycle after the granted read; until it has been
    // captured the write must take it straight from the RAM bus.
    always_comb begin
        fsm_we    = 1'b0;
        fsm_re    = 1'b0;
        fsm_addr  = '0;
        fsm_wdata = '0;
        unique case (state)
            S_PUT: begin
                fsm_we    = 1'b1;
                fsm_addr  = cur_addr;
                fsm_wdata = put_word;
            end
            S_CLEAR, S_SCROLL_FILL: begin
                fsm_we    = 1'b1;
                fsm_addr  = cnt;
                fsm_wdata = W_SPACE;
            end
            S_SCROLL_RD: begin
                fsm_re   = 1'b1;
                fsm_addr = cnt;
            end
            S_SCROLL_WR: begin
                fsm_we    = 1'b1;
                fsm_addr  = cnt - A_ROW1;
                fsm_wdata = rd_pend ? i_ram_rdata : hold;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            put_byte <= '0;
            put_inv  <= 1'b0;
            rd_pend  <= 1'b0;
            hold     <= '0;
        end else begin
            rd_pend <= (state == S_SCROLL_RD) & fsm_gnt;
            if (rd_pend) hold <= i_ram_rdata;
            if (fsm_gnt) begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            unique case (kind)
                                K_PRINT: begin
                                    put_byte <= i_ch_data;
                                    put_inv  <= i_inv;
                                    state    <= S_PUT;
                                end
                                K_CR: cur_x <= '0;
                                K_LF: begin
                                    if (cur_y == Y_LAST) begin
                                        cnt   <= A_ROW1;
                                        state <= S_SCROLL_RD;
                                    end else begin
                                        cur_y <= cur_y + 5'd1;
                                    end
                                end
                                K_BS: begin
                                    if (cur_x != '0) cur_x <= cur_x - 6'd1;
                                end
                                K_FF: begin
                                    cnt   <= '0;
                                    cur_x <= '0;
                                    cur_y <= '0;
                                    state <= S_CLEAR;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_PUT: begin
                        if (cur_x == X_LAST) begin
                            cur_x <= '0;
                            if (cur_y == Y_LAST) begin
                                cnt   <= A_ROW1;
                                state <= S_SCROLL_RD;
                            end else begin
                                cur_y <= cur_y + 5'd1;
                                state <= S_IDLE;
                            end
                        end else begin
                            cur_x <= cur_x + 6'd1;
                            state <= S_IDLE;
                        end
                    end
                    S_CLEAR, S_SCROLL_FILL: begin
                        if (cnt == A_LAST) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_SCROLL_RD: state <= S_SCROLL_WR;
                    S_SCROLL_WR: begin
                        if (cnt == A_LAST) begin
                            cnt   <= A_FILL;
                            state <= S_SCROLL_FILL;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_SCROLL_RD;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    osd_ram_arb #(
        .DW (DW)
    ) u_arb (
        .en        (rst_n),
        .host_wr   (i_host_wr),
        .host_addr (i_host_addr),
        .host_data (i_host_data),
        .fsm_we    (fsm_we),
        .fsm_re    (fsm_re),
        .fsm_addr  (fsm_addr),
        .fsm_wdata (fsm_wdata),
        .ram_we    (o_ram_we),
        .ram_re    (o_ram_re),
        .ram_addr  (o_ram_addr),
        .ram_wdata (o_ram_wdata),
        .fsm_gnt   (fsm_gnt)
    );

endmodule

// File: tb/tb_osd_console.sv
// Bench for osd_console: tile-RAM write stream scoreboarded against a
// row/column screen model, random text plus directed corner cases.
module tb_osd_console;

    localparam int CX = 64;
    localparam int CY = 24;
    localparam int N  = CX * CY;

    logic        clk_pixel = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_ch_valid = 1'b0;
    logic [7:0]  i_ch_data = '0;
    logic        o_ch_ready;
    logic        i_inv = 1'b0;
    logic        i_host_wr = 1'b0;
    logic [10:0] i_host_addr = '0;
    logic [8:0]  i_host_data = '0;
    logic        o_ram_we;
    logic        o_ram_re;
    logic [10:0] o_ram_addr;
    logic [8:0]  o_ram_wdata;
    logic [8:0]  i_ram_rdata = '0;
    logic [5:0]  o_cursor_x;
    logic [4:0]  o_cursor_y;
    logic        o_busy;

    always #5 clk_pixel = ~clk_pixel;

    osd_console #(
        .c_chars_x (CX),
        .c_chars_y (CY),
        .c_inverse (1)
    ) dut (
        .clk_pixel   (clk_pixel),
        .rst_n       (rst_n),
        .i_ch_valid  (i_ch_valid),
        .i_ch_data   (i_ch_data),
        .o_ch_ready  (o_ch_ready),
        .i_inv       (i_inv),
        .i_host_wr   (i_host_wr),
        .i_host_addr (i_host_addr),
        .i_host_data (i_host_data),
        .o_ram_we    (o_ram_we),
        .o_ram_re    (o_ram_re),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata),
        .o_cursor_x  (o_cursor_x),
        .o_cursor_y  (o_cursor_y),
        .o_busy      (o_busy)
    );

    logic [8:0] mem [N];

    always @(posedge clk_pixel) begin
        if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
        if (o_ram_re) i_ram_rdata <= mem[o_ram_addr];
    end

    typedef struct packed {
        logic [10:0] a;
        logic [8:0]  d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        w;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         rd_cnt = 0;
    int         busy_cnt = 0;
    int         ex = 0;
    int         ey = 0;
    logic [8:0] exp_scr [N];
    logic [8:0] snap [N];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    always @(negedge clk_pixel) begin
        if (rst_n) begin
            if (o_busy) busy_cnt++;
            if (o_ram_re) rd_cnt++;
            if (o_ram_we || o_ram_re)
                chk("we_re_excl", 32'(o_ram_we & o_ram_re), 32'd0);
            if (i_host_wr) begin
                chk("host_pass", 32'({o_ram_we, o_ram_addr, o_ram_wdata}),
                    32'({1'b1, i_host_addr, i_host_data}));
            end else if (o_ram_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_wr: addr %0d data 0x%0h, required no write",
                             o_ram_addr, o_ram_wdata);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_stream", 32'({o_ram_addr, o_ram_wdata}), 32'({w.a, w.d}));
                end
            end
            if (!o_busy && !i_host_wr)
                chk("idle_port", 32'({o_ram_we, o_ram_re, o_ram_addr}), 32'd0);
        end
    end

    task automatic push_wr(input int a, input logic [8:0] d);
        exp_q.push_back({11'(a), d});
        exp_scr[a] = d;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < CY - 1; r++)
            for (int c = 0; c < CX; c++)
                push_wr(r * CX + c, exp_scr[(r + 1) * CX + c]);
        for (int c = 0; c < CX; c++)
            push_wr((CY - 1) * CX + c, 9'h020);
    endtask

    task automatic model_char(input logic [7:0] b, input logic inv);
        if (b >= 8'h20 && b != 8'h7F) begin
            push_wr(ey * CX + ex, {inv, b});
            ex++;
            if (ex == CX) begin
                ex = 0;
                if (ey == CY - 1) model_scroll();
                else ey++;
            end
        end else if (b == 8'h0D) begin
            ex = 0;
        end else if (b == 8'h0A) begin
            if (ey == CY - 1) model_scroll();
            else ey++;
        end else if (b == 8'h08) begin
            if (ex > 0) ex--;
        end else if (b == 8'h0C) begin
            for (int a = 0; a < N; a++) push_wr(a, 9'h020);
            ex = 0;
            ey = 0;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic inv);
        int k;
        bit ok;
        model_char(b, inv);
        i_ch_valid = 1'b1;
        i_ch_data  = b;
        i_inv      = inv;
        k  = 0;
        ok = 0;
        while (!ok && k < 8000) begin
            @(negedge clk_pixel);
            if (o_ch_ready) ok = 1;
            k++;
        end
        if (!ok) fail_now("send_timeout", "o_ch_ready never rose");
        else @(posedge clk_pixel);
        #1;
        i_ch_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk_pixel);
            k++;
        end while (o_busy && k < 10000);
        if (o_busy) fail_now(tag, "o_busy stuck high past cycle budget");
        @(posedge clk_pixel);
        #1;
        chk({tag, "_q_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic host_burst(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            i_host_wr   = 1'b1;
            i_host_addr = 11'(base + i);
            i_host_data = 9'($urandom);
            exp_scr[base + i] = i_host_data;
            @(negedge clk_pixel);
            chk("host_blocks_ready", 32'(o_ch_ready), 32'd0);
            @(posedge clk_pixel);
            #1;
        end
        i_host_wr = 1'b0;
    endtask

    task automatic check_screen(input string tag);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int a = 0; a < N; a++) begin
            if (mem[a] !== exp_scr[a]) begin
                if (first < 0) first = a;
                bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d cells differ, first @%0d got 0x%0h required 0x%0h",
                     tag, bad, first, mem[first], exp_scr[first]);
        end
    endtask

    task automatic check_cursor(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(o_cursor_x), 32'(x));
        chk({tag, "_y"}, 32'(o_cursor_y), 32'(y));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(o_ram_we), 32'd0);
        chk({tag, "_re"}, 32'(o_ram_re), 32'd0);
        chk({tag, "_addr"}, 32'(o_ram_addr), 32'd0);
        chk({tag, "_ready"}, 32'(o_ch_ready), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        check_cursor(tag, 0, 0);
    endtask

    initial begin
        int b0;
        int r0;
        int k;
        bit hit;
        int r;
        logic [7:0] b;

        rst_n = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #1;
        check_reset_outputs("rst");
        i_host_wr = 1'b1;
        i_host_addr = 11'd5;
        i_host_data = 9'h1AA;
        i_ch_valid = 1'b1;
        #1;
        chk("rst_host_we", 32'(o_ram_we), 32'd0);
        chk("rst_ready", 32'(o_ch_ready), 32'd0);
        i_host_wr = 1'b0;
        i_ch_valid = 1'b0;
        @(posedge clk_pixel);
        #1;
        rst_n = 1'b1;
        @(posedge clk_pixel);
        #1;

        for (int a = 0; a < N; a++) begin
            i_host_wr   = 1'b1;
            i_host_addr = 11'(a);
            i_host_data = 9'($urandom);
            exp_scr[a]  = i_host_data;
            @(posedge clk_pixel);
            #1;
        end
        i_host_wr = 1'b0;
        check_screen("preload");

        send(8'h41, 1'b1);
        send(8'h42, 1'b1);
        wait_idle("ab");
        chk("ab_mem0", 32'(mem[0]), 32'h141);
        chk("ab_mem1", 32'(mem[1]), 32'h142);
        check_cursor("ab_cursor", 2, 0);

        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 99);
            if (r < 62)      b = 8'($urandom_range(32, 126));
            else if (r < 70) b = 8'($urandom_range(128, 255));
            else if (r < 76) b = 8'h0D;
            else if (r < 82) b = 8'h08;
            else if (r < 86) b = 8'h0A;
            else if (r < 92) b = 8'($urandom_range(0, 31));
            else             b = 8'h7F;
            if (r >= 96) begin
                wait_idle("rand_host");
                host_burst($urandom_range(0, N - 1), 1);
            end
            send(b, 1'($urandom_range(0, 1)));
        end
        wait_idle("rand");
        check_screen("rand_screen");
        check_cursor("rand_cursor", ex, ey);

        b0 = busy_cnt;
        send(8'h0C, 1'b0);
        wait_idle("ff");
        chk("ff_busy_cycles", 32'(busy_cnt - b0), 32'(N));
        check_screen("ff_screen");
        check_cursor("ff_cursor", 0, 0);

        r0 = rd_cnt;
        send(8'h08, 1'b0);
        wait_idle("bs0");
        check_cursor("bs_at_0", 0, 0);
        for (int i = 0; i < 5; i++) send(8'h0A, 1'b0);
        for (int i = 0; i < 10; i++) send(8'(8'h61 + i), 1'b0);
        wait_idle("to_10_5");
        check_cursor("at_10_5", 10, 5);
        send(8'h0D, 1'b0);
        wait_idle("cr");
        check_cursor("cr", 0, 5);
        send(8'h0A, 1'b0);
        wait_idle("lf");
        check_cursor("lf", 0, 6);
        chk("ctl_no_reads", 32'(rd_cnt - r0), 32'd0);
        check_screen("ctl_screen");

        for (int i = 0; i < 17; i++) send(8'h0A, 1'b0);
        for (int i = 0; i < 63; i++) send(8'($urandom_range(33, 126)), 1'($urandom_range(0, 1)));
        wait_idle("to_63_23");
        check_cursor("at_63_23", 63, 23);
        b0 = busy_cnt;
        r0 = rd_cnt;
        send(8'h5A, 1'b0);
        wait_idle("z_scroll");
        chk("z_busy_cycles", 32'(busy_cnt - b0), 32'(1 + 2 * (N - CX) + CX));
        chk("z_reads", 32'(rd_cnt - r0), 32'(N - CX));
        chk("z_moved", 32'(mem[N - 1 - CX]), 32'h05A);
        k = 0;
        for (int c = 0; c < CX; c++) if (mem[(CY - 1) * CX + c] != 9'h020) k++;
        chk("z_blank_row", 32'(k), 32'd0);
        check_screen("z_screen");
        check_cursor("z_cursor", 0, 23);

        b0 = busy_cnt;
        r0 = rd_cnt;
        send(8'h0A, 1'b0);
        repeat (400) @(posedge clk_pixel);
        #1;
        host_burst(0, 5);
        wait_idle("host_scroll");
        chk("host_scroll_cycles", 32'(busy_cnt - b0), 32'(2 * (N - CX) + CX + 5));
        chk("host_scroll_reads", 32'(rd_cnt - r0), 32'(N - CX));
        check_screen("host_scroll_screen");
        check_cursor("host_scroll_cursor", 0, 23);

        for (int a = 0; a < N; a++) snap[a] = exp_scr[a];
        send(8'h0C, 1'b0);
        hit = 0;
        k = 0;
        while (!hit && k < 3000) begin
            @(negedge clk_pixel);
            if (o_ram_we && !i_host_wr && o_ram_addr == 11'd700) hit = 1;
            k++;
        end
        if (!hit) fail_now("clr_700", "clear never reached address 700");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_clr_rst");
        exp_q.delete();
        for (int a = 0; a < N; a++) exp_scr[a] = (a < 700) ? 9'h020 : snap[a];
        ex = 0;
        ey = 0;
        repeat (3) @(posedge clk_pixel);
        #1;
        rst_n = 1'b1;
        repeat (50) @(posedge clk_pixel);
        #1;
        chk("post_rst_busy", 32'(o_busy), 32'd0);
        check_screen("post_rst_screen");
        check_cursor("post_rst_cursor", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/osd_console.md
OSD_CONSOLE -- requirements
Module: osd_console

Interface
REQ-001 SHALL have parameter c_chars_x, default 64, tile columns.
REQ-002 SHALL have parameter c_chars_y, default 24, tile rows.
REQ-003 SHALL have parameter c_inverse, default 1, tile word is 8+c_inverse bits and bit 8 is the inverse flag.
REQ-004 SHALL have port clk_pixel  in  1  sole clock; all logic rises on clk_pixel.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_ch_valid/i_ch_data  in  1/8  character stream; o_ch_ready  out  1.
REQ-007 SHALL have port i_inv  in  1  inverse attribute, sampled with each accepted printable character.
REQ-008 SHALL have port i_host_wr/i_host_addr/i_host_data  in  1/11/8+c_inverse  SPI-side tile write request.
REQ-009 SHALL have port o_ram_we/o_ram_re/o_ram_addr/o_ram_wdata  out  1/1/11/8+c_inverse  single tile-RAM port.
REQ-010 SHALL have port i_ram_rdata  in  8+c_inverse  read data, valid one cycle after o_ram_re.
REQ-011 SHALL have port o_cursor_x/o_cursor_y/o_busy  out  6/5/1  cursor position; o_busy is high when not IDLE.

Function
REQ-012 SHALL use the FSM states IDLE, PUT, CLEAR, SCROLL_RD, SCROLL_WR and SCROLL_FILL.
REQ-013 SHALL drive o_ch_ready = (state==IDLE) & ~i_host_wr; a character is accepted on the cycle i_ch_valid & o_ch_ready.
REQ-014 SHALL grant i_host_wr absolute priority: o_ram_* then carry the host write, the FSM holds state, counters hold and the cursor holds.
REQ-015 SHALL write a printable byte (0x20-0x7E, 0x80-0xFF) in PUT, the cycle after acceptance, as addr = y*c_chars_x+x, data {i_inv,byte}, with i_inv dropped when c_inverse=0.
REQ-016 SHALL advance the cursor after PUT: x+1; at x=c_chars_x-1, x=0 and y+1; at the last cell, enter SCROLL_RD and end with x=0, y=c_chars_y-1.
REQ-017 SHALL handle 0x0D as x=0; 0x0A as y+1, or scroll if y=c_chars_y-1, with x unchanged; 0x08 as x-1 if x>0 else no-op. Each completes in the acceptance cycle and returns to IDLE.
REQ-018 SHALL handle 0x0C by entering CLEAR, which writes 0x020 to addresses 0..N-1 (N=c_chars_x*c_chars_y) one per granted cycle; the cursor is then 0,0.
REQ-019 SHALL consume other bytes 0x00-0x1F and 0x7F with no RAM access.
REQ-020 SHALL scroll as follows: for a = c_chars_x..N-1, SCROLL_RD asserts o_ram_re at a, then SCROLL_WR writes the held rdata to a-c_chars_x.
REQ-021 SHALL then run SCROLL_FILL, which writes 0x020 to the last row.
REQ-022 SHALL capture i_ram_rdata into a hold register only on the cycle after a granted read; if a host write preempts SCROLL_RD, the read is retried.
REQ-023 SHALL take exactly 2*(N-c_chars_x)+c_chars_x cycles per scroll with no host activity; this is 3008 at default.
REQ-024 SHALL assert at most one of o_ram_we and o_ram_re per cycle; outputs are undefined-free, and o_ram_addr is 0 when idle.
REQ-025 SHALL not accept new characters during CLEAR or scroll; upstream sees o_ch_ready=0.

Reset
REQ-026 SHALL, while rst_n=0: state IDLE, cursor 0,0, all counters 0, hold register 0, o_ram_we=o_ram_re=0, o_ch_ready=0, o_busy=0.
REQ-027 SHALL, on reset mid-CLEAR or mid-scroll, abandon the operation immediately; RAM contents are left as-is and no write follows reset release.

Structure
REQ-028 SHALL place c_chars_x/c_chars_y-derived N, the address width, the control-code constants (CR, LF, BS, FF, SPACE) and the state encoding in shared package osd_pkg.
REQ-029 SHALL implement the host-priority port mux as sub-module osd_ram_arb; the FSM, cursor and sweep counter stay in osd_console.

Verification
REQ-030 SHALL verify reset then "AB" with i_inv=1 -> writes 0x141@0 and 0x142@1; cursor ends at 2,0.
REQ-031 SHALL verify cursor at 63,23 with 'Z' sent -> write 0x05A@1535, then 3008-cycle scroll; row 22 equals prior row 23 and row 23 is all 0x020; cursor ends at 0,23.
REQ-032 SHALL verify 0x0C -> 1536 writes of 0x020; o_busy high for the whole sweep; cursor ends at 0,0.
REQ-033 SHALL verify i_host_wr held 5 cycles mid-scroll -> the host writes appear verbatim, scroll length becomes 3013, and the moved data is intact.
REQ-034 SHALL verify 0x08 at x=0, and 0x0D/0x0A at 10,5 -> no-op; then x=0; then 0,6; no RAM accesses occur.
REQ-035 SHALL verify rst_n pulsed low mid-CLEAR at address 700 -> outputs at reset values at once; no write after release; cursor is 0,0.
